// File: rtl/spi_master_seq.sv
// rtl/spi_master_seq.sv - SPI word sequencer with TX FIFO, inter-word gap and SCK watchdog
module spi_master_seq #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int TMO   = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  output logic            busy,
  output logic            err,
  output logic            spi_en,
  output logic [SIZE-1:0] spi_tx,
  input  logic            spi_sck,
  input  logic [SIZE-1:0] spi_rx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SIZE + 1);
  localparam int WW = $clog2(TMO + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  logic            sck_q;
  logic            fall;
  logic            last_fall;
  logic            timeout;
  logic [CW-1:0]   fall_cnt;
  logic [WW-1:0]   wdog;
  logic [GW-1:0]   gap_cnt;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;

  // SCK is only sampled; a falling edge is high-then-low across one clk
  assign fall      = sck_q && !spi_sck;
  assign last_fall = fall && (fall_cnt == CW'(SIZE - 1));
  assign timeout   = !fall && (wdog == WW'(TMO - 1));

  assign busy      = (state != S_IDLE) || !empty;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, pop request and SPI enable decode
  always_comb begin
    state_nxt = state;
    spi_en    = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_XFER;
      end
      S_XFER: begin
        spi_en = 1'b1;
        if (last_fall) begin
          state_nxt = S_DONE;
        end else if (timeout) begin
          state_nxt = S_GAP;
        end
      end
      S_DONE: begin
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers wrap modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Outgoing word is loaded only on a pop and held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_tx <= '0;
    end else if (pop) begin
      spi_tx <= mem[rd_ptr[AW-1:0]];
    end
  end

  // SCK history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= spi_sck;
    end
  end

  // Fall counter and watchdog: cleared in LOAD, advanced only in XFER
  always_ff @(posedge clk) begin
    if (rst || state == S_LOAD) begin
      fall_cnt <= '0;
      wdog     <= '0;
    end else if (state == S_XFER) begin
      if (fall) begin
        fall_cnt <= fall_cnt + CW'(1);
        wdog     <= '0;
      end else begin
        wdog     <= wdog + WW'(1);
      end
    end
  end

  // Gap timer runs only while in GAP
  always_ff @(posedge clk) begin
    if (rst || state != S_GAP) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Result capture in DONE and watchdog strobe; both land as one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= (state == S_DONE);
      err       <= (state == S_XFER) && timeout;
      if (state == S_DONE) begin
        out_data <= spi_rx;
      end
    end
  end

endmodule
